// File: rtl/uart_tx_framer.sv
// uart_tx_framer
//
// Serialises one parallel word per request into an asynchronous frame:
// start bit (0), DATA_WIDTH data bits LSB first, an optional even/odd parity
// bit, then STOP_BITS stop bits (1). Every bit lasts CLKS_PER_BIT clocks.
//
// Parameters
//   DATA_WIDTH   data bits per frame (5..9)
//   CLKS_PER_BIT clock cycles per serial bit (>= 2)
//   STOP_BITS    number of stop bits (1 or 2)
//
// Ports
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   P_DATA     parallel word to transmit
//   Data_Valid request strobe
//   PAR_EN     1 = append a parity bit
//   PAR_TYP    0 = even parity, 1 = odd parity
//   TX_OUT     registered serial line, idle high
//   Busy       registered, high while a frame is on the line
//
// Handshake: a request is a single clock with Data_Valid=1 while the framer
// is idle. The word and the parity settings are captured on that edge, and
// Busy rises on the following edge together with the start bit. Requests
// made while the framer is not idle are dropped, not queued. Busy falling
// means the line is free; the framer can accept again in that same cycle.
module uart_tx_framer #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      bit_cnt;
  logic [IDX_W-1:0]      bit_idx;
  logic                  stop_cnt;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_q;
  logic                  line;
  logic                  bit_done;
  logic                  last_bit;
  logic                  last_stop;

  assign bit_done  = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign last_bit  = (bit_idx == IDX_W'(DATA_WIDTH - 1));
  // With one stop bit the first stop period is already the last one.
  assign last_stop = (STOP_BITS == 1) || stop_cnt;

  // Next state and the line level belonging to the current state.
  always_comb begin
    state_next = state;
    line       = 1'b1;
    case (state)
      IDLE: begin
        if (Data_Valid) state_next = START;
      end
      START: begin
        line = 1'b0;
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        line = data_q[bit_idx];
        if (bit_done && last_bit) state_next = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        line = par_q;
        if (bit_done) state_next = STOP;
      end
      STOP: begin
        if (bit_done && last_stop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The outputs are registered from the current state, so the line follows
  // the state by one clock: a request accepted at one edge shows its start
  // bit from the next edge, and Busy drops one edge after the state is IDLE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      TX_OUT   <= 1'b1;
      Busy     <= 1'b0;
    end else begin
      state  <= state_next;
      TX_OUT <= line;
      Busy   <= (state != IDLE);
      if (state == IDLE) begin
        bit_cnt  <= '0;
        bit_idx  <= '0;
        stop_cnt <= 1'b0;
        if (Data_Valid) begin
          data_q   <= P_DATA;
          par_en_q <= PAR_EN;
          // Parity is fixed at acceptance: odd parity is the inverted XOR.
          par_q    <= (^P_DATA) ^ PAR_TYP;
        end
      end else begin
        bit_cnt <= bit_done ? '0 : bit_cnt + CNT_W'(1);
        if (state == DATA && bit_done && !last_bit) begin
          bit_idx <= bit_idx + IDX_W'(1);
        end
        if (state == STOP && bit_done) begin
          stop_cnt <= ~stop_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer
//
// Two framer instances share one clock and reset: dut1 uses the default
// format (8 data bits, 16 clocks per bit, 1 stop bit); dut2 uses 4 clocks
// per bit and 2 stop bits. The expected line is built per clock from the
// frame's bit list ({busy, tx} per cycle) and compared each falling edge.
module tb_uart_tx_framer;

  localparam int CPB1  = 16;
  localparam int STOP1 = 1;
  localparam int CPB2  = 4;
  localparam int STOP2 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] p_data1, p_data2;
  logic       dv1, dv2, par_en1, par_en2, par_typ1, par_typ2;
  logic       tx1, tx2, busy1, busy2;

  uart_tx_framer #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB1), .STOP_BITS(STOP1)) dut1 (
    .CLK(clk), .RST(rst), .P_DATA(p_data1), .Data_Valid(dv1),
    .PAR_EN(par_en1), .PAR_TYP(par_typ1), .TX_OUT(tx1), .Busy(busy1)
  );

  uart_tx_framer #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB2), .STOP_BITS(STOP2)) dut2 (
    .CLK(clk), .RST(rst), .P_DATA(p_data2), .Data_Valid(dv2),
    .PAR_EN(par_en2), .PAR_TYP(par_typ2), .TX_OUT(tx2), .Busy(busy2)
  );

  // ---------------- scoreboard ----------------
  logic [1:0] exp1_q[$];
  logic [1:0] exp2_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  logic [1:0] e1, e2;
  always @(negedge clk) begin
    if (exp1_q.size() > 0) begin
      e1 = exp1_q.pop_front();
      check("dut1_line", 32'({busy1, tx1}), 32'(e1));
    end
    if (exp2_q.size() > 0) begin
      e2 = exp2_q.pop_front();
      check("dut2_line", 32'({busy2, tx2}), 32'(e2));
    end
  end

  // ---------------- reference model ----------------
  function automatic void push_exp(input int which, input logic [1:0] v);
    if (which == 1) exp1_q.push_back(v);
    else            exp2_q.push_back(v);
  endfunction

  function automatic int qsize(input int which);
    return (which == 1) ? exp1_q.size() : exp2_q.size();
  endfunction

  function automatic int frame_len(input int which, input logic pe);
    int cpb, stops;
    cpb   = (which == 1) ? CPB1 : CPB2;
    stops = (which == 1) ? STOP1 : STOP2;
    return (1 + 8 + int'(pe) + stops) * cpb;
  endfunction

  // One idle clock (the acceptance cycle) followed by the whole frame.
  function automatic void push_frame(input int which, input logic [7:0] d,
                                     input logic pe, input logic pt);
    logic bits[$];
    int   cpb, stops;
    cpb   = (which == 1) ? CPB1 : CPB2;
    stops = (which == 1) ? STOP1 : STOP2;
    push_exp(which, 2'b01);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pe) bits.push_back((^d) ^ pt);
    for (int s = 0; s < stops; s++) bits.push_back(1'b1);
    foreach (bits[i]) begin
      for (int c = 0; c < cpb; c++) push_exp(which, {1'b1, bits[i]});
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input int which, input logic [7:0] d, input logic pe,
                        input logic pt, input logic v);
    if (which == 1) begin
      p_data1 = d; par_en1 = pe; par_typ1 = pt; dv1 = v;
    end else begin
      p_data2 = d; par_en2 = pe; par_typ2 = pt; dv2 = v;
    end
  endtask

  function automatic logic get_busy(input int which);
    return (which == 1) ? busy1 : busy2;
  endfunction

  task automatic wait_drain(input int which);
    int b = 0;
    while (qsize(which) > 0 && b < 2000) begin
      @(negedge clk);
      b++;
    end
    check("drain_timeout", 32'(qsize(which)), 32'd0);
  endtask

  task automatic expect_idle(input int which, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (which == 1) check(tag, 32'({busy1, tx1}), 32'd1);
      else            check(tag, 32'({busy2, tx2}), 32'd1);
    end
  endtask

  // One request; inputs are scrambled right after acceptance. With noise
  // they keep changing during the frame and Data_Valid pulses randomly,
  // stopping two cycles before the framer can accept again.
  task automatic send(input int which, input logic [7:0] d, input logic pe,
                      input logic pt, input bit noise);
    int len;
    len = frame_len(which, pe);
    @(negedge clk);
    set_in(which, d, pe, pt, 1'b1);
    @(posedge clk);
    #1;
    set_in(which, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    push_frame(which, d, pe, pt);
    push_exp(which, 2'b01);
    if (noise) begin
      for (int i = 0; i < len - 2; i++) begin
        @(negedge clk);
        set_in(which, 8'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom_range(0, 5) == 0));
      end
      set_in(which, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end
    wait_drain(which);
  endtask

  // Data_Valid held high across two frames.
  task automatic back_to_back(input int which, input logic [7:0] d1,
                              input logic [7:0] d2, input logic pe, input logic pt);
    @(negedge clk);
    set_in(which, d1, pe, pt, 1'b1);
    @(posedge clk);
    #1;
    set_in(which, d2, pe, pt, 1'b1);
    push_frame(which, d1, pe, pt);
    push_frame(which, d2, pe, pt);
    push_exp(which, 2'b01);
    repeat (frame_len(which, pe) + 1) @(posedge clk);
    #1;
    set_in(which, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    wait_drain(which);
  endtask

  task automatic measure_busy(input int which, output int cnt);
    int t = 0;
    cnt = 0;
    while (!get_busy(which) && t < 10) begin
      @(negedge clk);
      t++;
    end
    while (get_busy(which) && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    logic [7:0] d;
    rst = 1'b1;
    set_in(1, 8'h00, 1'b0, 1'b0, 1'b0);
    set_in(2, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_tx1", 32'(tx1), 32'd1);
    check("reset_busy1", 32'(busy1), 32'd0);
    check("reset_tx2", 32'(tx2), 32'd1);
    check("reset_busy2", 32'(busy2), 32'd0);
    rst = 1'b0;
    expect_idle(1, 3, "idle_after_reset");

    // Even parity, 0xA5
    fork
      send(1, 8'hA5, 1'b1, 1'b0, 1'b0);
      measure_busy(1, cnt);
    join
    check("busy_len_a5", 32'(cnt), 32'd176);

    // Odd parity edge values
    send(1, 8'h80, 1'b1, 1'b1, 1'b1);
    send(1, 8'h00, 1'b1, 1'b1, 1'b0);

    // Parity disabled
    fork
      send(1, 8'($urandom), 1'b0, 1'($urandom), 1'b0);
      measure_busy(1, cnt);
    join
    check("busy_len_nopar", 32'(cnt), 32'd160);

    // Request while busy is dropped
    fork
      send(1, 8'hC3, 1'b1, 1'b0, 1'b0);
      begin
        repeat (40) @(negedge clk);
        set_in(1, 8'h3C, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        set_in(1, 8'h3C, 1'b0, 1'b1, 1'b0);
      end
    join
    expect_idle(1, 20, "busy_req_ignored");

    // Back-to-back
    back_to_back(1, 8'h55, 8'hAA, 1'($urandom), 1'($urandom));
    expect_idle(1, 5, "b2b_idle");

    // Reset during DATA bit 3
    d = 8'($urandom);
    @(negedge clk);
    set_in(1, d, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    set_in(1, 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    push_frame(1, d, 1'b1, 1'b0);
    repeat (4 * CPB1 + 5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp1_q.delete();
    expect_idle(1, 5, "rst_mid_idle");
    send(1, 8'($urandom), 1'b1, 1'($urandom), 1'b0);

    // Reset and request together: reset wins
    @(negedge clk);
    rst = 1'b1;
    set_in(1, 8'h5A, 1'b1, 1'b1, 1'b1);
    set_in(2, 8'h5A, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_in(1, 8'h00, 1'b0, 1'b0, 1'b0);
    set_in(2, 8'h00, 1'b0, 1'b0, 1'b0);
    expect_idle(1, 20, "rst_dv_idle1");
    expect_idle(2, 4, "rst_dv_idle2");

    // Random frames on dut1
    for (int i = 0; i < 8; i++) begin
      send(1, 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end

    // Two stop bits, dut2
    fork
      send(2, 8'hFF, 1'b0, 1'b0, 1'b0);
      measure_busy(2, cnt);
    join
    check("busy_len_2stop", 32'(cnt), 32'd44);
    for (int i = 0; i < 12; i++) begin
      send(2, 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    end
    back_to_back(2, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    expect_idle(2, 5, "b2b_idle2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
